// File: rtl/csr_fifo_endpoint.sv
// csr_fifo_endpoint: register-map FIFO endpoint; writes push words, read requests pop one word each.
// Latency: rvalid one cycle after a read-request edge on a non-empty FIFO; or one cycle after the write that fills a pending read.
// Backpressure: wready = (count < DEPTH), no bypass when full; pending reads time out after RD_TIMEOUT cycles with rdata = 0.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   wen/wdata/wready    write request (held until accepted) and acceptance
//   ren                 read request, rising edge detected (pulse or level)
//   rvalid/rdata        one-cycle read response strobe and data (held between strobes)
//   flush               synchronous clear of contents and read FSM
//   count               number of stored words
//   underflow           sticky: a read timed out (cleared only by rst)
module csr_fifo_endpoint #(
    parameter int DATA_W     = 24,
    parameter int DEPTH      = 8,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen,
    input  logic [DATA_W-1:0]          wdata,
    output logic                       wready,
    input  logic                       ren,
    output logic                       rvalid,
    output logic [DATA_W-1:0]          rdata,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(RD_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      wait_q, wait_d;
    logic               tmo_q, tmo_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               underflow_q, underflow_d;
    logic               ren_q, ren_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               push;
    logic               pop;
    logic               req;
    logic [DATA_W-1:0]  resp_word;

    // wready depends only on registered count, never on the read side.
    assign wready    = (count_q < CW'(DEPTH));
    assign push      = wen && wready;
    assign req       = ren && !ren_q;
    // flush kills a response in flight; the head word then stays stored only
    // until the flush clears it on the same edge.
    assign rvalid    = (state_q == S_RESP) && !flush;
    assign pop       = rvalid && !tmo_q;
    assign resp_word = tmo_q ? '0 : mem[rd_ptr_q];
    assign rdata     = rvalid ? resp_word : rdata_q;
    assign count     = count_q;
    assign underflow = underflow_q;

    // Read FSM next-state
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (count_q != '0) begin
                        state_d = S_RESP;
                        tmo_d   = 1'b0;
                    end else begin
                        state_d = S_PEND;
                        wait_d  = '0;
                    end
                end
            end
            S_PEND: begin
                // A word written this cycle is stored at the closing edge and
                // becomes the head, so it can be answered in the next cycle.
                if (count_q != '0 || push) begin
                    state_d = S_RESP;
                    tmo_d   = 1'b0;
                end else if (wait_q == TW'(RD_TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // FIFO pointers, occupancy and response registers
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rdata_d     = rdata;
        underflow_d = underflow_q | (rvalid && tmo_q);
        ren_d       = ren;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            tmo_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            underflow_q <= 1'b0;
            ren_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            tmo_q       <= tmo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            underflow_q <= underflow_d;
            ren_q       <= ren_d;
        end
    end

    // Storage array is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_csr_fifo_endpoint.sv
module tb_csr_fifo_endpoint;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [23:0] wdata;
    logic        wready;
    logic        ren;
    logic        rvalid;
    logic [23:0] rdata;
    logic        flush;
    logic [3:0]  count;
    logic        underflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csr_fifo_endpoint #(.DATA_W(24), .DEPTH(8), .RD_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .wready(wready),
        .ren(ren), .rvalid(rvalid), .rdata(rdata), .flush(flush),
        .count(count), .underflow(underflow)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [23:0] d);
        int n;
        n = 0;
        wen = 1'b1;
        wdata = d;
        @(negedge clk);
        while (!wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 50) begin n_err++; $display("FAIL write_accept: wready stayed %b, required 1", wready); end
        step();
        wen = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wen = 1'b0; wdata = '0; ren = 1'b0; flush = 1'b0;
        #12;
        @(negedge clk);
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d, required 0", count); end
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b, required 0", rvalid); end
        n_vec++; if (rdata !== 24'h0) begin n_err++; $display("FAIL rst_rdata: got %h, required 0", rdata); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_underflow: got %b, required 0", underflow); end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (wready !== 1'b1) begin n_err++; $display("FAIL rst_wready: got %b, required 1", wready); end
        step();
    endtask

    task automatic test_fifo_order();
        logic [23:0] exp [5];
        exp[0] = 24'h000000; exp[1] = 24'h001001; exp[2] = 24'h002004;
        exp[3] = 24'h003009; exp[4] = 24'h004010;
        for (int i = 0; i < 5; i++) do_write(24'((i + 4096) * i));
        @(negedge clk);
        n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL order_count5: got %0d, required 5", count); end
        step();
        for (int i = 0; i < 5; i++) begin
            ren = 1'b1;
            @(negedge clk);
            n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL order_early_rvalid[%0d]: got %b, required 0", i, rvalid); end
            step();
            ren = 1'b0;
            @(negedge clk);
            n_vec++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL order_rvalid[%0d]: got %b, required 1", i, rvalid); end
            n_vec++; if (rdata !== exp[i]) begin n_err++; $display("FAIL order_rdata[%0d]: got %h, required %h", i, rdata, exp[i]); end
            step();
        end
        @(negedge clk);
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL order_count0: got %0d, required 0", count); end
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL order_rvalid_after: got %b, required 0", rvalid); end
        n_vec++; if (rdata !== 24'h004010) begin n_err++; $display("FAIL order_rdata_hold: got %h, required 004010", rdata); end
        step();
    endtask

    task automatic test_full();
        logic [23:0] e;
        for (int i = 0; i < 8; i++) do_write(24'h10 + 24'(i));
        wen = 1'b1; wdata = 24'hAABBCC;
        @(negedge clk);
        n_vec++; if (wready !== 1'b0) begin n_err++; $display("FAIL full_wready: got %b, required 0", wready); end
        n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL full_count: got %0d, required 8", count); end
        step();
        ren = 1'b1;
        @(negedge clk);
        n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL full_hold_count: got %0d, required 8", count); end
        step();
        ren = 1'b0;
        @(negedge clk);
        n_vec++; if (rvalid !== 1'b1 || rdata !== 24'h10) begin n_err++; $display("FAIL full_read: rvalid %b rdata %h, required 1 000010", rvalid, rdata); end
        n_vec++; if (wready !== 1'b0) begin n_err++; $display("FAIL full_wready_resp: got %b, required 0", wready); end
        step();
        @(negedge clk);
        n_vec++; if (wready !== 1'b1 || count !== 4'd7) begin n_err++; $display("FAIL full_after_pop: wready %b count %0d, required 1 7", wready, count); end
        step();
        wen = 1'b0;
        @(negedge clk);
        n_vec++; if (count !== 4'd8 || wready !== 1'b0) begin n_err++; $display("FAIL full_ninth: count %0d wready %b, required 8 0", count, wready); end
        step();
        for (int i = 0; i < 8; i++) begin
            e = (i == 7) ? 24'hAABBCC : 24'h11 + 24'(i);
            ren = 1'b1;
            step();
            ren = 1'b0;
            @(negedge clk);
            n_vec++; if (rvalid !== 1'b1 || rdata !== e) begin n_err++; $display("FAIL full_drain[%0d]: rvalid %b rdata %h, required 1 %h", i, rvalid, rdata, e); end
            step();
        end
        @(negedge clk);
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL full_drained: got %0d, required 0", count); end
        step();
    endtask

    task automatic test_pend_write();
        int early;
        early = 0;
        ren = 1'b1;
        step();
        ren = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (rvalid) early++;
            step();
        end
        wen = 1'b1; wdata = 24'h123456;
        @(negedge clk);
        if (rvalid) early++;
        step();
        wen = 1'b0;
        n_vec++; if (early !== 0) begin n_err++; $display("FAIL pend_early: %0d strobes, required 0", early); end
        @(negedge clk);
        n_vec++; if (rvalid !== 1'b1 || rdata !== 24'h123456) begin n_err++; $display("FAIL pend_resp: rvalid %b rdata %h, required 1 123456", rvalid, rdata); end
        step();
        @(negedge clk);
        n_vec++; if (count !== 4'd0 || underflow !== 1'b0) begin n_err++; $display("FAIL pend_after: count %0d underflow %b, required 0 0", count, underflow); end
        step();
    endtask

    task automatic test_timeout();
        int first;
        first = -1;
        ren = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (rvalid && first < 0) begin
                first = k;
                n_vec++; if (rdata !== 24'h0) begin n_err++; $display("FAIL tmo_rdata: got %h, required 0", rdata); end
            end
            step();
            ren = 1'b0;
        end
        n_vec++; if (first !== 17) begin n_err++; $display("FAIL tmo_latency: rvalid at cycle %0d, required 17", first); end
        @(negedge clk);
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL tmo_underflow: got %b, required 1", underflow); end
        step();
        do_flush();
        @(negedge clk);
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL tmo_underflow_flush: got %b, required 1", underflow); end
        step();
    endtask

    task automatic test_flush();
        do_write(24'h000111);
        do_write(24'h000222);
        ren = 1'b1;
        step();
        ren = 1'b0; flush = 1'b1; wen = 1'b1; wdata = 24'h000333;
        @(negedge clk);
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL flush_rvalid: got %b, required 0", rvalid); end
        n_vec++; if (rdata !== 24'h0) begin n_err++; $display("FAIL flush_rdata_hold: got %h, required 0", rdata); end
        step();
        flush = 1'b0; wen = 1'b0;
        @(negedge clk);
        n_vec++; if (count !== 4'd0 || rvalid !== 1'b0) begin n_err++; $display("FAIL flush_after: count %0d rvalid %b, required 0 0", count, rvalid); end
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL flush_underflow: got %b, required 1", underflow); end
        step();
    endtask

    task automatic test_level();
        int strobes;
        strobes = 0;
        for (int i = 0; i < 3; i++) do_write(24'h00A000 + 24'(i));
        ren = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) ren = 1'b0;
            @(negedge clk);
            if (rvalid) begin
                strobes++;
                n_vec++; if (rdata !== 24'h00A000) begin n_err++; $display("FAIL level_rdata: got %h, required 00a000", rdata); end
            end
            step();
        end
        n_vec++; if (strobes !== 1) begin n_err++; $display("FAIL level_strobes: got %0d, required 1", strobes); end
        @(negedge clk);
        n_vec++; if (count !== 4'd2) begin n_err++; $display("FAIL level_count: got %0d, required 2", count); end
        step();
    endtask

    task automatic test_reset_pend();
        int strobes;
        strobes = 0;
        do_write(24'h000777);
        do_flush();
        ren = 1'b1;
        step();
        ren = 1'b0;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (count !== 4'd0 || rvalid !== 1'b0) begin n_err++; $display("FAIL rstpend_state: count %0d rvalid %b, required 0 0", count, rvalid); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rstpend_underflow: got %b, required 0", underflow); end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (wready !== 1'b1) begin n_err++; $display("FAIL rstpend_wready: got %b, required 1", wready); end
        for (int i = 0; i < 25; i++) begin
            if (rvalid) strobes++;
            @(negedge clk);
        end
        n_vec++; if (strobes !== 0) begin n_err++; $display("FAIL rstpend_rvalid: %0d strobes, required 0", strobes); end
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL rstpend_count: got %0d, required 0", count); end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_full();
        test_pend_write();
        test_timeout();
        test_flush();
        test_level();
        test_reset_pend();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
